// File: rtl/decode_rf.sv
// decode_rf: instruction decode stage with a 2-read/1-write register file and a
// single-entry valid/ready output register. Optional macro DECODE_RF_BYPASS_EN
// forwards a same-cycle writeback into the registered operands.
module decode_rf #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter int IMW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_inst,
  input  logic           flush,
  input  logic           wb_en,
  input  logic [RFW-1:0] wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  inst,
  output logic [DW-1:0]  dataA,
  output logic [DW-1:0]  dataB
);

  localparam int NREG = 2 ** RFW;

  // Opcode, rd, rs1, rs2 and the immediate must all fit in one instruction word.
  if (IW < 5 + 3 * RFW + IMW) begin : g_bad_widths
    $error("decode_rf: IW too small for opcode, rd, rs1, rs2 and immediate fields");
  end

  logic [DW-1:0]  r_rf [NREG];
  logic           r_out_valid;
  logic [IW-1:0]  r_inst;
  logic [DW-1:0]  r_data_a;
  logic [DW-1:0]  r_data_b;

  logic [RFW-1:0] w_rs1;
  logic [RFW-1:0] w_rs2;
  logic           w_accept;
  logic [DW-1:0]  w_rd_a;
  logic [DW-1:0]  w_rd_b;

  assign w_rs1    = in_inst[IW-6-RFW   -: RFW];
  assign w_rs2    = in_inst[IW-6-2*RFW -: RFW];
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // NOTE: every variable is given a default first so no latch is inferred.
  always_comb begin
    w_rd_a = r_rf[w_rs1];
    w_rd_b = r_rf[w_rs2];
`ifdef DECODE_RF_BYPASS_EN
    if (wb_en && (wb_addr == w_rs1)) w_rd_a = wb_data;
    if (wb_en && (wb_addr == w_rs2)) w_rd_b = wb_data;
`endif
    // Register 0 overrides any bypass: it always reads as zero.
    if (w_rs1 == '0) w_rd_a = '0;
    if (w_rs2 == '0) w_rd_b = '0;
  end

  // NOTE: the register file is reset like ordinary flops so every entry reads
  // zero after reset; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_inst      <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_inst      <= in_inst;
      r_data_a    <= w_rd_a;
      r_data_b    <= w_rd_b;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign inst      = r_inst;
  assign dataA     = r_data_a;
  assign dataB     = r_data_b;

endmodule

// File: tb/tb_decode_rf.sv
// Self-checking bench for decode_rf: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register file and output slot.
module tb_decode_rf;

  localparam int RFW = 5;
  localparam int DW  = 32;
  localparam int IW  = 32;
  localparam int IMW = 4;
`ifdef DECODE_RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_inst;
  logic           flush;
  logic           wb_en;
  logic [RFW-1:0] wb_addr;
  logic [DW-1:0]  wb_data;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  inst;
  logic [DW-1:0]  dataA;
  logic [DW-1:0]  dataB;

  decode_rf #(.RFW(RFW), .DW(DW), .IW(IW), .IMW(IMW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .dataA(dataA), .dataB(dataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_rf [32];
  logic [96:0]   got;
  logic [96:0]   exp;

  localparam logic [31:0] INST_A = 32'h8e7425b7;

  function automatic logic [31:0] mk_inst(int rs1, int rs2, logic [31:0] noise);
    logic [31:0] r;
    r = noise;
    r[21:17] = rs1[4:0];
    r[16:12] = rs2[4:0];
    return r;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] word, int which);
    int r;
    r = (which == 1) ? int'((word >> 17) & 32'd31) : int'((word >> 12) & 32'd31);
    if (r == 0) return 32'd0;
    if (BYPASS && wb_en && (int'(wb_addr) == r)) return wb_data;
    return model_rf[r];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_inst   = '0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_wb(int a, logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a[4:0];
    wb_data = d;
    step();
    wb_en = 1'b0;
    if (a != 0) model_rf[a] = d;
  endtask

  task automatic test_reset();
    idle();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_inst  = INST_A;
    wb_en    = 1'b1;
    wb_addr  = 5'd26;
    wb_data  = 32'd123;
    repeat (2) step();
    got = {out_valid, inst, dataA, dataB};
    exp = '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", got, exp);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    foreach (model_rf[i]) model_rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_en = 1'b0;
    step();
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, INST_A, 32'd0, 32'd0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_first_accept: got %h expected %h", got, exp);
    end
    idle();
    step();
  endtask

  task automatic test_basic();
    do_wb(26, 32'd445);
    do_wb(2, 32'd1);
    in_valid = 1'b1;
    in_inst  = INST_A;
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, INST_A, 32'd445, 32'd1};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL basic_accept: got %h expected %h", got, exp);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] inst_b;
    inst_b    = mk_inst(2, 26, 32'h1c00_0abc);
    in_valid  = 1'b1;
    in_inst   = INST_A;
    out_ready = 1'b0;
    step();
    in_inst = inst_b;
    exp = {1'b1, INST_A, model_rf[26], model_rf[2]};
    for (int c = 0; c < 3; c++) begin
      step();
      got = {out_valid, inst, dataA, dataB};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got %h expected %h", c, got, exp);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_ready cycle %0d: got %b expected 0", c, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, inst_b, model_rf[2], model_rf[26]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stall_next_accept: got %h expected %h", got, exp);
    end
    step();
  endtask

  task automatic test_r0();
    logic [31:0] w;
    do_wb(0, 32'hFFFF_FFFF);
    w        = mk_inst(0, 26, 32'h0);
    in_valid = 1'b1;
    in_inst  = w;
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, w, 32'd0, model_rf[26]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL r0_read_zero: got %h expected %h", got, exp);
    end
    step();
  endtask

  task automatic test_same_cycle_wb();
    in_valid = 1'b1;
    in_inst  = INST_A;
    wb_en    = 1'b1;
    wb_addr  = 5'd26;
    wb_data  = 32'd7;
    step();
    wb_en = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, INST_A, (BYPASS ? 32'd7 : 32'd445), 32'd1};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL same_cycle_wb: got %h expected %h", got, exp);
    end
    model_rf[26] = 32'd7;
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, INST_A, 32'd7, 32'd1};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL same_cycle_wb_after: got %h expected %h", got, exp);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] y;
    y         = mk_inst(5, 2, 32'h4000_0123);
    in_valid  = 1'b1;
    in_inst   = INST_A;
    out_ready = 1'b0;
    step();
    in_inst = y;
    flush   = 1'b1;
    wb_en   = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'h55;
    step();
    flush = 1'b0;
    wb_en = 1'b0;
    model_rf[5] = 32'h55;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b0, INST_A, model_rf[26], model_rf[2]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_drop: got %h expected %h", got, exp);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, y, 32'h55, model_rf[2]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_wb_kept: got %h expected %h", got, exp);
    end
    step();
  endtask

  task automatic test_async_reset();
    in_valid  = 1'b1;
    in_inst   = INST_A;
    out_ready = 1'b0;
    step();
    #2;
    rst_n   = 1'b0;
    wb_en   = 1'b1;
    wb_addr = 5'd26;
    wb_data = 32'd99;
    #1;
    got = {out_valid, inst, dataA, dataB};
    exp = '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, exp);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_no_pulse: got %b expected 0", out_valid);
    end
    foreach (model_rf[i]) model_rf[i] = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    wb_en     = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    got = {out_valid, inst, dataA, dataB};
    exp = {1'b1, INST_A, 32'd0, 32'd0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset_rf_cleared: got %h expected %h", got, exp);
    end
    step();
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_inst, m_a, m_b;
    logic        acc;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    foreach (model_rf[i]) model_rf[i] = '0;
    m_valid = 1'b0;
    m_inst  = '0;
    m_a     = '0;
    m_b     = '0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      in_inst   = mk_inst($urandom_range(0, 7), $urandom_range(0, 7), $urandom());
      #1;
      n_checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_fail++;
        $display("FAIL rand_in_ready iter %0d: got %b expected %b", n, in_ready, !m_valid || out_ready);
      end
      acc = in_valid && (!m_valid || out_ready);
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_inst  = in_inst;
        m_a     = model_read(in_inst, 1);
        m_b     = model_read(in_inst, 2);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && (wb_addr != 0)) model_rf[wb_addr] = wb_data;
      step();
      got = {out_valid, inst, dataA, dataB};
      exp = {m_valid, m_inst, m_a, m_b};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_outputs iter %0d: got %h expected %h", n, got, exp);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_r0();
    test_same_cycle_wb();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
